// File: rtl/ahb_ram_ctrl_wait_if.sv
// AHB-lite slave-side bus bundle for the wait-state RAM controller.
interface ahb_ram_ctrl_wait_if;
  logic        HSEL;
  logic [1:0]  HTRANS;
  logic [2:0]  HSIZE;
  logic        HWRITE;
  logic [31:0] HADDR;
  logic [31:0] HWDATA;
  logic        HREADY;
  logic        HREADYOUT;
  logic        HRESP;
  logic [31:0] HRDATA;

  modport master (
    output HSEL, HTRANS, HSIZE, HWRITE, HADDR, HWDATA, HREADY,
    input  HREADYOUT, HRESP, HRDATA
  );
  modport slave (
    input  HSEL, HTRANS, HSIZE, HWRITE, HADDR, HWDATA, HREADY,
    output HREADYOUT, HRESP, HRDATA
  );
endinterface

// File: rtl/ahb_ram_ctrl_wait.sv
// AHB-lite RAM slave: byte/half/word writes, programmable wait states,
// two-cycle ERROR response and write-to-read forwarding.
module ahb_ram_ctrl_wait #(
  parameter int unsigned RAM_SIZE    = 8192,
  parameter logic [31:0] RAM_START   = 32'h0002_0000,
  parameter int unsigned WAIT_STATES = 0
) (
  input  logic               CLK,
  input  logic               RST,
  ahb_ram_ctrl_wait_if.slave bus
);
  localparam int AW  = $clog2(RAM_SIZE);
  localparam int AWX = (AW > 2) ? AW : 3;
  localparam int IW  = AWX - 2;
  localparam logic [31:0] RAM_LAST = RAM_START + 32'(RAM_SIZE) - 32'd1;
  localparam logic [3:0]  WS_LAST  = 4'((WAIT_STATES > 0) ? WAIT_STATES - 1 : 0);

  typedef enum logic [2:0] {S_IDLE, S_WAIT, S_DATA, S_ERR1, S_ERR2} state_t;

  state_t          r_state, w_nxt, w_tgt;
  logic [3:0]      r_wcnt;
  logic [IW-1:0]   r_idx;
  logic [2:0]      r_size;
  logic [1:0]      r_lane;
  logic            r_write;
  logic [31:0]     r_hrdata;
  logic [31:0]     r_mem [2**IW];

  logic            w_can, w_acc, w_err, w_we, w_fwd, w_rd_load;
  logic [IW-1:0]   w_idx, w_rd_idx;
  logic [3:0]      w_strb;
  logic [31:0]     w_rd_word, w_rd_data;

  function automatic logic [3:0] f_strb(input logic [2:0] sz, input logic [1:0] ln);
    case (sz)
      3'b000:  f_strb = 4'b0001 << ln;
      3'b001:  f_strb = ln[1] ? 4'b1100 : 4'b0011;
      default: f_strb = 4'b1111;
    endcase
  endfunction

  assign w_can = (r_state == S_IDLE) || (r_state == S_DATA) || (r_state == S_ERR2);
  assign w_acc = w_can && bus.HSEL && bus.HTRANS[1] && bus.HREADY;
  assign w_err = (bus.HADDR < RAM_START) || (bus.HADDR > RAM_LAST) ||
                 (bus.HSIZE == 3'b001 && bus.HADDR[0]) ||
                 (bus.HSIZE == 3'b010 && bus.HADDR[1:0] != 2'b00) ||
                 (bus.HSIZE > 3'b010);
  assign w_idx = IW'((bus.HADDR - RAM_START) >> 2);
  assign w_tgt = w_err ? S_ERR1 : ((WAIT_STATES > 0) ? S_WAIT : S_DATA);

  always_comb begin
    w_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_acc) w_nxt = w_tgt;
      S_WAIT:  if (r_wcnt == WS_LAST) w_nxt = S_DATA;
      S_DATA:  w_nxt = w_acc ? w_tgt : S_IDLE;
      S_ERR1:  w_nxt = S_ERR2;
      S_ERR2:  w_nxt = w_acc ? w_tgt : S_IDLE;
      default: w_nxt = S_IDLE;
    endcase
  end

  assign bus.HREADYOUT = !((r_state == S_WAIT) || (r_state == S_ERR1));
  assign bus.HRESP     = (r_state == S_ERR1) || (r_state == S_ERR2);
  assign bus.HRDATA    = r_hrdata;

  assign w_we   = (r_state == S_DATA) && r_write;
  assign w_strb = f_strb(r_size, r_lane);

  // Read data is captured on the edge that enters DATA: straight from the
  // address phase with no wait states, or from the held index after WAIT.
  assign w_rd_load = (r_state == S_WAIT) ? ((w_nxt == S_DATA) && !r_write)
                                         : (w_acc && !bus.HWRITE && (w_tgt == S_DATA));
  assign w_rd_idx  = (r_state == S_WAIT) ? r_idx : w_idx;
  assign w_rd_word = r_mem[w_rd_idx];
  // The write committing on this same edge is not yet in the array.
  assign w_fwd     = w_we && (r_idx == w_rd_idx);

  always_comb begin
    w_rd_data = w_rd_word;
    for (int n = 0; n < 4; n++)
      if (w_fwd && w_strb[n]) w_rd_data[8*n +: 8] = bus.HWDATA[8*n +: 8];
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state  <= S_IDLE;
      r_wcnt   <= '0;
      r_idx    <= '0;
      r_size   <= '0;
      r_lane   <= '0;
      r_write  <= 1'b0;
      r_hrdata <= '0;
    end else begin
      r_state <= w_nxt;
      r_wcnt  <= (r_state == S_WAIT) ? r_wcnt + 4'd1 : 4'd0;
      if (w_acc) begin
        r_idx   <= w_idx;
        r_size  <= bus.HSIZE;
        r_lane  <= bus.HADDR[1:0];
        r_write <= bus.HWRITE;
      end
      if (w_rd_load) r_hrdata <= w_rd_data;
    end
  end

  // Contents are not reset; a reset edge must never commit a write.
  always_ff @(posedge CLK) begin
    if (w_we && !RST)
      for (int n = 0; n < 4; n++)
        if (w_strb[n]) r_mem[r_idx][8*n +: 8] <= bus.HWDATA[8*n +: 8];
  end
endmodule

// File: tb/tb_ahb_ram_ctrl_wait.sv
// Bench for ahb_ram_ctrl_wait: a zero-wait and a three-wait instance behind a
// shared master, checked against a byte-array model of the RAM.
module tb_ahb_ram_ctrl_wait;
  localparam int unsigned RS = 8192;
  localparam logic [31:0] RB = 32'h0002_0000;

  typedef struct packed {
    logic        wr;
    logic [2:0]  sz;
    logic [31:0] a;
    logic [31:0] d;
  } xfer_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  bit          sel = 1'b0;
  logic        hsel = 1'b0, hwrite = 1'b0;
  logic [1:0]  htrans = 2'b00;
  logic [2:0]  hsize = 3'b010;
  logic [31:0] haddr = '0, hwdata = '0;
  logic        hro, hresp;
  logic [31:0] hrd;

  ahb_ram_ctrl_wait_if b0 ();
  ahb_ram_ctrl_wait_if b3 ();

  assign b0.HSEL = hsel && !sel;  assign b3.HSEL = hsel && sel;
  assign b0.HTRANS = htrans;      assign b3.HTRANS = htrans;
  assign b0.HSIZE = hsize;        assign b3.HSIZE = hsize;
  assign b0.HWRITE = hwrite;      assign b3.HWRITE = hwrite;
  assign b0.HADDR = haddr;        assign b3.HADDR = haddr;
  assign b0.HWDATA = hwdata;      assign b3.HWDATA = hwdata;
  assign b0.HREADY = b0.HREADYOUT;
  assign b3.HREADY = b3.HREADYOUT;
  assign hro   = sel ? b3.HREADYOUT : b0.HREADYOUT;
  assign hresp = sel ? b3.HRESP     : b0.HRESP;
  assign hrd   = sel ? b3.HRDATA    : b0.HRDATA;

  ahb_ram_ctrl_wait #(.RAM_SIZE(RS), .RAM_START(RB), .WAIT_STATES(0)) u_dut0 (
    .CLK(clk), .RST(rst), .bus(b0));
  ahb_ram_ctrl_wait #(.RAM_SIZE(RS), .RAM_START(RB), .WAIT_STATES(3)) u_dut3 (
    .CLK(clk), .RST(rst), .bus(b3));

  int ntests = 0, nfail = 0;
  logic [7:0]  mb [2][RS];
  int          ws [2] = '{0, 3};
  logic [31:0] exp_rd [2] = '{32'h0, 32'h0};
  logic [31:0] rdlog [$];
  xfer_t       q [$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    ntests++;
    assert (got === exp) else begin
      nfail++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic bit is_err(input xfer_t x);
    return (x.a < RB) || (x.a > RB + RS - 1) ||
           (x.sz == 3'd1 && x.a[0]) || (x.sz == 3'd2 && x.a[1:0] != 2'b00) ||
           (x.sz > 3'd2);
  endfunction

  function automatic logic [31:0] mread(input bit s, input logic [31:0] a);
    int w = int'((a - RB) & 32'hFFFF_FFFC);
    return {mb[s][w+3], mb[s][w+2], mb[s][w+1], mb[s][w]};
  endfunction

  task automatic mwrite(input bit s, input xfer_t x);
    int off = int'(x.a - RB);
    for (int k = 0; k < (1 << x.sz); k++) begin
      int ln = (int'(x.a[1:0]) + k) % 4;
      mb[s][off + k] = x.d[8*ln +: 8];
    end
  endtask

  function automatic logic [31:0] rd_at(input int k);
    return (rdlog.size() > k) ? rdlog[k] : 32'hxxxx_xxxx;
  endfunction

  task automatic add(input bit wr, input logic [2:0] sz, input logic [31:0] a, input logic [31:0] d);
    xfer_t x;
    x.wr = wr; x.sz = sz; x.a = a; x.d = d;
    q.push_back(x);
  endtask

  task automatic add_rand();
    logic [31:0] a = RB + 32'($urandom_range(0, 63));
    logic [2:0]  sz = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(3, 7)) : 3'($urandom_range(0, 2));
    case ($urandom_range(0, 11))
      0: a = RB + RS + 32'($urandom_range(0, 7));
      1: a = RB - 32'd1 - 32'($urandom_range(0, 7));
      default: ;
    endcase
    add(1'($urandom), sz, a, $urandom);
  endtask

  // Pipelined master: address of the next transfer overlaps the current data phase.
  task automatic run_q(input bit gaps);
    int idx = 0, low = 0, cyc = 0;
    bit dpv = 0, pres;
    xfer_t dp = '0;
    rdlog.delete();
    while (idx < q.size() || dpv) begin
      pres = (idx < q.size()) && !(gaps && $urandom_range(0, 3) == 0);
      if (pres) begin
        hsel = 1'b1; htrans = 2'b10; hsize = q[idx].sz; hwrite = q[idx].wr; haddr = q[idx].a;
      end else begin
        case ($urandom_range(0, 2))
          0: begin hsel = 1'b0; htrans = 2'b10; end
          1: begin hsel = 1'b1; htrans = 2'b00; end
          default: begin hsel = 1'b1; htrans = 2'b01; end
        endcase
        hsize = 3'b010; hwrite = 1'($urandom); haddr = RB + 32'($urandom_range(0, 15) * 4);
      end
      hwdata = dpv ? dp.d : $urandom;
      @(negedge clk);
      if (dpv) begin
        if (!hro) begin
          low++;
          chk("resp_during_wait", {31'b0, hresp}, {31'b0, is_err(dp)});
        end else begin
          chk("wait_cycles", low, is_err(dp) ? 1 : ws[sel]);
          chk("resp_final", {31'b0, hresp}, {31'b0, is_err(dp)});
          if (!is_err(dp)) begin
            if (dp.wr) mwrite(sel, dp);
            else begin
              exp_rd[sel] = mread(sel, dp.a);
              rdlog.push_back(hrd);
            end
          end
          chk("hrdata", hrd, exp_rd[sel]);
          dpv = 0; low = 0;
        end
      end
      if (hro && pres) begin
        dp = q[idx]; idx++; dpv = 1;
      end
      cyc++;
      if (cyc > 3000) begin
        chk("timeout_cycles", cyc, 32'd0);
        break;
      end
      @(posedge clk); #1;
    end
    hsel = 1'b0; htrans = 2'b00;
    q.delete();
  endtask

  initial begin
    logic [31:0] old;
    repeat (3) @(posedge clk);
    #1;
    for (int s = 0; s < 2; s++) begin
      sel = 1'(s); #1;
      chk("reset_hreadyout", {31'b0, hro}, 32'd1);
      chk("reset_hresp", {31'b0, hresp}, 32'd0);
      chk("reset_hrdata", hrd, 32'd0);
    end
    @(negedge clk) rst = 1'b0;
    @(posedge clk); #1;

    // Give the words used below a known value in both instances.
    for (int s = 0; s < 2; s++) begin
      sel = 1'(s);
      for (int i = 0; i < 16; i++) add(1'b1, 3'd2, RB + 32'(4 * i), $urandom);
      run_q(1'b0);
    end

    sel = 1'b0;
    add(1'b1, 3'd2, RB, 32'hDEAD_BEEF); add(1'b0, 3'd2, RB, 32'h0);
    run_q(1'b0);
    chk("tp_word_rw", rd_at(0), 32'hDEAD_BEEF);

    add(1'b1, 3'd2, RB + 32'h4, 32'h1122_3344);
    add(1'b1, 3'd0, RB + 32'h6, 32'h0055_0000);
    add(1'b0, 3'd2, RB + 32'h4, 32'h0);
    add(1'b1, 3'd1, RB + 32'h6, 32'hAAAA_0000);
    add(1'b0, 3'd2, RB + 32'h4, 32'h0);
    run_q(1'b0);
    chk("tp_byte_lane2", rd_at(0), 32'h1155_3344);
    chk("tp_half_hi", rd_at(1), 32'hAAAA_3344);

    add(1'b1, 3'd2, RB + 32'h10, 32'h1234_5678); add(1'b0, 3'd2, RB + 32'h10, 32'h0);
    run_q(1'b0);
    chk("tp_forward", rd_at(0), 32'h1234_5678);

    add(1'b0, 3'd2, RB + RS, 32'h0);
    add(1'b1, 3'd2, RB + 32'h2, 32'hFFFF_FFFF);
    add(1'b0, 3'd2, RB, 32'h0);
    run_q(1'b0);
    chk("tp_err_no_write", rd_at(0), 32'hDEAD_BEEF);

    for (int i = 0; i < 250; i++) add_rand();
    run_q(1'b1);

    sel = 1'b1;
    add(1'b1, 3'd2, RB + 32'h8, 32'h0BAD_CAFE); add(1'b0, 3'd2, RB + 32'h8, 32'h0);
    run_q(1'b0);
    chk("tp_ws3_read", rd_at(0), 32'h0BAD_CAFE);
    for (int i = 0; i < 120; i++) add_rand();
    run_q(1'b1);

    // Reset lands in the middle of a write's wait states.
    old = mread(1'b1, RB + 32'h20);
    hsel = 1'b1; htrans = 2'b10; hsize = 3'd2; hwrite = 1'b1; haddr = RB + 32'h20;
    @(posedge clk); #1;
    hsel = 1'b0; htrans = 2'b00; hwdata = ~old;
    @(posedge clk); #1;
    chk("rst_pre_wait", {31'b0, hro}, 32'd0);
    rst = 1'b1; #1;
    chk("rst_mid_hreadyout", {31'b0, hro}, 32'd1);
    chk("rst_mid_hresp", {31'b0, hresp}, 32'd0);
    chk("rst_mid_hrdata", hrd, 32'd0);
    exp_rd[0] = 32'h0; exp_rd[1] = 32'h0;
    @(posedge clk);
    @(negedge clk) rst = 1'b0;
    @(posedge clk); #1;
    add(1'b0, 3'd2, RB + 32'h20, 32'h0);
    run_q(1'b0);
    chk("rst_dropped_write", rd_at(0), old);

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end
endmodule

// File: doc/ahb_ram_ctrl_wait.md
Name: ahb_ram_ctrl_wait

Overview:
- Parametrised successor RAM slave on the core's AHB-lite style bus, with a true address phase and a true data phase.
- Adds byte/halfword/word writes via HSIZE with little-endian byte lanes, and configurable wait states via HREADYOUT.
- Adds a two-cycle ERROR response for out-of-range or misaligned accesses, and write-to-read forwarding.
- Sits between the bus interconnect and an internally inferred synchronous word array; contents are not reset.

Parameters:
- RAM_SIZE, 8192: bytes of storage; power of two, >= 4.
- RAM_START, 32'h0002_0000: base byte address; RAM_SIZE-aligned.
- WAIT_STATES, 0: extra HREADYOUT-low cycles per OKAY data phase; range 0..15.

Ports:
- CLK  input  1  system clock, all state on rising edge
- RST  input  1  asynchronous, active-high reset
- HSEL  input  1  slave select from decoder
- HTRANS  input  2  00 IDLE, 01 BUSY, 10 NONSEQ, 11 SEQ
- HSIZE  input  3  000 byte, 001 halfword, 010 word; others are an error
- HWRITE  input  1  1 = write
- HADDR  input  32  byte address (address phase)
- HWDATA  input  32  write data (data phase)
- HREADY  input  1  bus-level ready; an address phase is accepted only when high
- HREADYOUT  output  1  slave ready
- HRESP  output  1  0 OKAY, 1 ERROR
- HRDATA  output  32  read data; valid when HREADYOUT=1 and HRESP=0 in a read data phase

Behaviour:
- Reset (async, RST=1):
  - HREADYOUT=1, HRESP=0, HRDATA=0, state IDLE, wait counter 0, pending-write valid=0.
  - A transfer in flight is dropped and no RAM write occurs.
- Accept condition: HSEL & HTRANS[1] & HREADY at a rising edge. BUSY and IDLE are ignored and leave state unchanged.
- On accept, register HADDR, HSIZE and HWRITE; the next cycle is the data phase.
- Error check on accepted address:
  - Out of range: HADDR < RAM_START or HADDR > RAM_START+RAM_SIZE-1.
  - Misaligned: halfword with HADDR[0]=1, or word with HADDR[1:0]!=0.
  - Bad size: HSIZE > 010.
- State machine:
  - IDLE: on accept, go to ERR1 if error; else WAIT if WAIT_STATES>0; else DATA.
  - WAIT: HREADYOUT=0. Count WAIT_STATES cycles, then go to DATA.
  - DATA: HREADYOUT=1, HRESP=0, transfer completes this cycle. A new accept in the same cycle (pipelined) re-enters ERR1/WAIT/DATA per the new address; otherwise return to IDLE.
  - ERR1: HREADYOUT=0, HRESP=1, one cycle, then ERR2.
  - ERR2: HREADYOUT=1, HRESP=1. Go to IDLE, or to the next transfer if one is accepted. An ERROR transfer never writes RAM.
- Word index = (HADDR-RAM_START)[log2(RAM_SIZE)-1:2].
- Write:
  - Commit occurs at the rising edge ending the DATA cycle, using HWDATA sampled in that cycle.
  - Byte strobe is derived from size and HADDR[1:0]:
    - byte: bit HADDR[1:0]
    - halfword: 0011 or 1100
    - word: 1111
  - Lane n maps to HWDATA[8n+7:8n]; unselected bytes are unchanged.
- Read:
  - The word is read from the array and driven unshifted on HRDATA (AHB lane convention).
  - HRDATA holds its value until the next read completes. It is 0 after reset and unchanged after writes and errors.
- Forwarding: if a read's data phase directly follows a write data phase to the same word, HRDATA shows the merged new bytes. A read never returns stale data, at any WAIT_STATES setting.
- Back-to-back accepted transfers sustain one transfer per cycle when WAIT_STATES=0.
- Address wrap: RAM_START+RAM_SIZE is out of range and does not alias to word 0.

Test Plan:
- Reset, then word write 0xDEADBEEF @0x0002_0000, then word read @0x0002_0000 (WAIT_STATES=0) -> HRDATA=0xDEADBEEF, HREADYOUT never low, HRESP=0.
- Byte write 0x55 in lane 2 @0x0002_0006 over prior word 0x11223344 @0x0002_0004 -> read returns 0x11553344. Halfword write 0xAAAA in lanes 3:2 @0x0002_0006 -> read returns 0xAAAA3344.
- Pipelined write 0x12345678 @0x0002_0010 immediately followed by read of the same address -> forwarded HRDATA=0x12345678 in the very next data phase.
- WAIT_STATES=3, single read -> HREADYOUT low exactly 3 cycles, then high with valid data.
- Word read @0x0002_2000 (RAM_START+RAM_SIZE) and word write @0x0002_0002 -> HREADYOUT=0/HRESP=1 then HREADYOUT=1/HRESP=1. RAM contents unchanged.
- RST asserted during a WAIT cycle of a write -> outputs go to reset values immediately, and a later read of that address shows the old data.
